// File: rtl/credit_seq_pkg.sv
// credit_seq_pkg: shared FSM state type and hex segment table for the credit sequencer
package credit_seq_pkg;
    typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} state_t;
    localparam logic [15:0][6:0] SEG_HEX = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };
endpackage

// File: rtl/seg7_hex_decoder.sv
// seg7_hex_decoder: combinational 4-bit to active-high {g,f,e,d,c,b,a} hex pattern
module seg7_hex_decoder
    import credit_seq_pkg::*;
(
    input  logic [3:0] val,
    output logic [6:0] seg
);
    assign seg = SEG_HEX[val];
endmodule

// File: rtl/credit_stage_sequencer.sv
// credit_stage_sequencer: coin credit gate for a button-stepped stage sequence with cancel/refund and timeout
module credit_stage_sequencer
    import credit_seq_pkg::*;
#(
    parameter int CREDIT_W = 4,
    parameter int PRICE    = 3,
    parameter int N_STAGES = 8,
    parameter int TIMEOUT  = 1000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                coin_vld,
    input  logic [CREDIT_W-1:0] coin_val,
    input  logic                adv_btn,
    input  logic                cancel_btn,
    output logic [CREDIT_W-1:0] credit,
    output logic                has_credit,
    output logic [3:0]          stage,
    output logic [6:0]          seg,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic                refund_vld,
    output logic [CREDIT_W-1:0] refund_val
);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [CREDIT_W-1:0] CMAX = '1;
    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
    localparam logic [3:0] NST = 4'(N_STAGES);

    function automatic logic [CREDIT_W-1:0] sat_add(input logic [CREDIT_W-1:0] a, input logic [CREDIT_W-1:0] b);
        logic [CREDIT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CREDIT_W] ? CMAX : s[CREDIT_W-1:0];
    endfunction

    logic [1:0] adv_sync_q, cancel_sync_q;
    logic adv_prev_q, cancel_prev_q, adv_e, cancel_e;
    state_t state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d, refund_val_q, refund_val_d, coin_amt;
    logic [3:0] stage_q, stage_d;
    logic [TW-1:0] timer_q, timer_d;
    logic aborted_q, aborted_d, refund_vld_q, refund_vld_d;
    logic has_credit_q, busy_q, done_q;
    logic [6:0] seg_q, seg_d;

    assign adv_e = adv_sync_q[1] & ~adv_prev_q;
    assign cancel_e = cancel_sync_q[1] & ~cancel_prev_q;

    // Synchronisers keep running while ena=0 so a press made then is simply lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adv_sync_q <= '0;
            cancel_sync_q <= '0;
            adv_prev_q <= 1'b0;
            cancel_prev_q <= 1'b0;
        end else begin
            adv_sync_q <= {adv_sync_q[0], adv_btn};
            cancel_sync_q <= {cancel_sync_q[0], cancel_btn};
            adv_prev_q <= adv_sync_q[1];
            cancel_prev_q <= cancel_sync_q[1];
        end
    end

    always_comb begin
        state_d = state_q;
        credit_d = credit_q;
        stage_d = stage_q;
        aborted_d = aborted_q;
        refund_vld_d = 1'b0;
        refund_val_d = refund_val_q;
        timer_d = '0;
        coin_amt = coin_vld ? coin_val : '0;
        if ((state_q == IDLE || state_q == ARMED) && cancel_e) begin
            refund_vld_d = 1'b1;
            refund_val_d = credit_q;
            credit_d = '0;
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    credit_d = sat_add(credit_q, coin_amt);
                    state_d = credit_q >= PRICE_C ? ARMED : IDLE;
                end
                ARMED: begin
                    credit_d = sat_add(adv_e ? credit_q - PRICE_C : credit_q, coin_amt);
                    if (adv_e) begin
                        state_d = RUN;
                        stage_d = 4'd1;
                        aborted_d = 1'b0;
                    end
                end
                RUN: begin
                    timer_d = timer_q + TW'(timer_q != TLAST);
                    if (cancel_e || timer_q == TLAST) begin
                        state_d = DONE;
                        aborted_d = 1'b1;
                    end else if (adv_e) begin
                        timer_d = '0;
                        state_d = stage_q == NST ? DONE : RUN;
                        stage_d = stage_q == NST ? stage_q : stage_q + 4'd1;
                    end
                end
                DONE: begin
                    if (adv_e || cancel_e) begin
                        stage_d = '0;
                        state_d = credit_q >= PRICE_C ? ARMED : IDLE;
                    end
                end
            endcase
        end
    end

    seg7_hex_decoder u_dec (.val(stage_d), .seg(seg_d));

    // Status outputs are registered from next-state values so they line up with state/credit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            credit_q <= '0;
            stage_q <= '0;
            timer_q <= '0;
            aborted_q <= 1'b0;
            refund_vld_q <= 1'b0;
            refund_val_q <= '0;
            has_credit_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            seg_q <= SEG_HEX[0];
        end else if (ena) begin
            state_q <= state_d;
            credit_q <= credit_d;
            stage_q <= stage_d;
            timer_q <= timer_d;
            aborted_q <= aborted_d;
            refund_vld_q <= refund_vld_d;
            refund_val_q <= refund_val_d;
            has_credit_q <= credit_d >= PRICE_C;
            busy_q <= state_d == RUN;
            done_q <= state_d == DONE;
            seg_q <= seg_d;
        end
    end

    assign credit = credit_q;
    assign has_credit = has_credit_q;
    assign stage = stage_q;
    assign seg = seg_q;
    assign busy = busy_q;
    assign done = done_q;
    assign aborted = aborted_q;
    assign refund_vld = refund_vld_q;
    assign refund_val = refund_val_q;
endmodule

// File: tb/tb_credit_stage_sequencer.sv
// tb_credit_stage_sequencer: table, directed and random checks against a cycle-level reference model
module tb_credit_stage_sequencer;
    localparam int PRICE = 3, NST = 8, TIMEOUT = 1000, CMAX = 15;
    localparam int P_IDLE = 0, P_ARMED = 1, P_RUN = 2, P_DONE = 3;
    localparam logic [23:0] RESET_VEC = {4'd0, 1'b0, 4'd0, 7'h3F, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};

    logic clk = 1'b0, rst_n = 1'b1, ena = 1'b0, coin_vld = 1'b0, adv_btn = 1'b0, cancel_btn = 1'b0;
    logic [3:0] coin_val = '0;
    logic [3:0] credit, stage, refund_val;
    logic [6:0] seg;
    logic has_credit, busy, done, aborted, refund_vld;
    int errors = 0, checks = 0;

    int m_phase, m_credit, m_stage, m_refval, m_idle;
    logic m_abort, m_refvld;
    logic [3:0] adv_h, can_h;
    logic [6:0] exp_seg [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [23:0] snap;
    logic ra, rc;

    typedef struct {
        logic cv; logic [3:0] cval; logic adv; logic can; int hold;
        logic [3:0] e_credit; logic [3:0] e_stage; logic e_busy; logic e_done; logic [6:0] e_seg;
    } vec_t;
    vec_t tbl [13];

    credit_stage_sequencer #(.CREDIT_W(4), .PRICE(PRICE), .N_STAGES(NST), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .coin_vld(coin_vld), .coin_val(coin_val),
        .adv_btn(adv_btn), .cancel_btn(cancel_btn), .credit(credit), .has_credit(has_credit),
        .stage(stage), .seg(seg), .busy(busy), .done(done), .aborted(aborted),
        .refund_vld(refund_vld), .refund_val(refund_val)
    );

    always #5 clk = ~clk;

    function automatic int sat(input int v);
        return v > CMAX ? CMAX : v;
    endfunction

    function automatic logic [23:0] dut_vec();
        return {credit, has_credit, stage, seg, busy, done, aborted, refund_vld, refund_val};
    endfunction

    function automatic logic [23:0] exp_vec();
        return {4'(m_credit), m_credit >= PRICE, 4'(m_stage), exp_seg[m_stage],
                m_phase == P_RUN, m_phase == P_DONE, m_abort, m_refvld, 4'(m_refval)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE; m_credit = 0; m_stage = 0; m_refval = 0; m_idle = 0;
        m_abort = 1'b0; m_refvld = 1'b0; adv_h = '0; can_h = '0;
    endtask

    // A pin rise is seen by the sequencer on the third sampling edge after it.
    task automatic model_step(input logic en, input logic cv, input int cval, input logic a, input logic c);
        logic ae, ce;
        int add;
        adv_h = {adv_h[2:0], a};
        can_h = {can_h[2:0], c};
        ae = adv_h[2] & ~adv_h[3];
        ce = can_h[2] & ~can_h[3];
        if (!en) return;
        m_refvld = 1'b0;
        add = cv ? cval : 0;
        if ((m_phase == P_IDLE || m_phase == P_ARMED) && ce) begin
            m_refvld = 1'b1; m_refval = m_credit; m_credit = 0; m_phase = P_IDLE;
        end else if (m_phase == P_IDLE) begin
            if (m_credit >= PRICE) m_phase = P_ARMED;
            m_credit = sat(m_credit + add);
        end else if (m_phase == P_ARMED) begin
            if (ae) begin
                m_credit = sat(m_credit - PRICE + add);
                m_stage = 1; m_abort = 1'b0; m_idle = 0; m_phase = P_RUN;
            end else m_credit = sat(m_credit + add);
        end else if (m_phase == P_RUN) begin
            m_idle++;
            if (ce || m_idle == TIMEOUT) begin
                m_phase = P_DONE; m_abort = 1'b1;
            end else if (ae) begin
                m_idle = 0;
                if (m_stage == NST) m_phase = P_DONE;
                else m_stage++;
            end
        end else if (ae || ce) begin
            m_stage = 0;
            m_phase = m_credit >= PRICE ? P_ARMED : P_IDLE;
        end
    endtask

    task automatic cycle(input logic cv, input logic [3:0] cval, input logic a, input logic c);
        coin_vld = cv; coin_val = cval; adv_btn = a; cancel_btn = c;
        @(posedge clk);
        #1;
        model_step(ena, cv, int'(cval), a, c);
        check("model", 32'(dut_vec()), 32'(exp_vec()));
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        coin_vld = 1'b0; adv_btn = 1'b0; cancel_btn = 1'b0;
        rst_n = 1'b0;
        #1;
        check("reset", 32'(dut_vec()), 32'(RESET_VEC));
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 4'd2,  1'b0, 1'b0, 2, 4'd2,  4'd0, 1'b0, 1'b0, 7'h3F};
        tbl[1]  = '{1'b1, 4'd2,  1'b0, 1'b0, 2, 4'd4,  4'd0, 1'b0, 1'b0, 7'h3F};
        tbl[2]  = '{1'b0, 4'd0,  1'b1, 1'b0, 3, 4'd1,  4'd1, 1'b1, 1'b0, 7'h06};
        tbl[3]  = '{1'b0, 4'd0,  1'b1, 1'b0, 3, 4'd1,  4'd2, 1'b1, 1'b0, 7'h5B};
        tbl[4]  = '{1'b0, 4'd0,  1'b1, 1'b0, 3, 4'd1,  4'd3, 1'b1, 1'b0, 7'h4F};
        tbl[5]  = '{1'b0, 4'd0,  1'b1, 1'b0, 3, 4'd1,  4'd4, 1'b1, 1'b0, 7'h66};
        tbl[6]  = '{1'b0, 4'd0,  1'b1, 1'b0, 3, 4'd1,  4'd5, 1'b1, 1'b0, 7'h6D};
        tbl[7]  = '{1'b0, 4'd0,  1'b1, 1'b0, 3, 4'd1,  4'd6, 1'b1, 1'b0, 7'h7D};
        tbl[8]  = '{1'b0, 4'd0,  1'b1, 1'b0, 3, 4'd1,  4'd7, 1'b1, 1'b0, 7'h07};
        tbl[9]  = '{1'b0, 4'd0,  1'b1, 1'b0, 3, 4'd1,  4'd8, 1'b1, 1'b0, 7'h7F};
        tbl[10] = '{1'b0, 4'd0,  1'b1, 1'b0, 3, 4'd1,  4'd8, 1'b0, 1'b1, 7'h7F};
        tbl[11] = '{1'b0, 4'd0,  1'b1, 1'b0, 3, 4'd1,  4'd0, 1'b0, 1'b0, 7'h3F};
        tbl[12] = '{1'b1, 4'd15, 1'b0, 1'b0, 2, 4'd15, 4'd0, 1'b0, 1'b0, 7'h3F};

        #2;
        do_reset();
        ena = 1'b1;
        for (int i = 0; i < 13; i++) begin
            cycle(tbl[i].cv, tbl[i].cval, tbl[i].adv, tbl[i].can);
            idle(tbl[i].hold);
            check($sformatf("tbl%0d_credit", i), 32'(credit), 32'(tbl[i].e_credit));
            check($sformatf("tbl%0d_stage", i), 32'(stage), 32'(tbl[i].e_stage));
            check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
            check($sformatf("tbl%0d_done", i), 32'(done), 32'(tbl[i].e_done));
            check($sformatf("tbl%0d_seg", i), 32'(seg), 32'(tbl[i].e_seg));
        end
        check("sat_has_credit", 32'(has_credit), 32'd1);

        cycle(1'b0, 4'd0, 1'b0, 1'b1);
        idle(2);
        check("refund15_val", 32'(refund_val), 32'd15);
        cycle(1'b1, 4'd2, 1'b0, 1'b0);
        cycle(1'b1, 4'd3, 1'b0, 1'b0);
        idle(2);
        check("armed5_credit", 32'(credit), 32'd5);
        cycle(1'b0, 4'd0, 1'b0, 1'b1);
        idle(2);
        check("refund_vld", 32'(refund_vld), 32'd1);
        check("refund_val5", 32'(refund_val), 32'd5);
        check("refund_credit0", 32'(credit), 32'd0);
        idle(1);
        check("refund_pulse_end", 32'(refund_vld), 32'd0);

        cycle(1'b1, 4'd3, 1'b0, 1'b0);
        idle(2);
        cycle(1'b0, 4'd0, 1'b1, 1'b0);
        check("adv_lat1", 32'(busy), 32'd0);
        idle(1);
        check("adv_lat2", 32'(busy), 32'd0);
        cycle(1'b1, 4'd2, 1'b0, 1'b0);
        check("adv_lat3_busy", 32'(busy), 32'd1);
        check("start_coin_credit", 32'(credit), 32'd2);

        repeat (50) cycle(1'b0, 4'd0, 1'b1, 1'b0);
        idle(3);
        check("held_adv_stage", 32'(stage), 32'd2);

        cycle(1'b0, 4'd0, 1'b1, 1'b0);
        idle(3);
        check("pre_timeout_stage", 32'(stage), 32'd3);
        for (int i = 0; i < 1100 && !done; i++) idle(1);
        check("timeout_done", 32'(done), 32'd1);
        check("timeout_aborted", 32'(aborted), 32'd1);
        check("timeout_stage", 32'(stage), 32'd3);

        cycle(1'b0, 4'd0, 1'b0, 1'b1);
        idle(3);
        check("done_exit_stage", 32'(stage), 32'd0);
        check("done_exit_no_refund", 32'(refund_vld), 32'd0);

        cycle(1'b1, 4'd5, 1'b0, 1'b0);
        idle(2);
        cycle(1'b0, 4'd0, 1'b1, 1'b1);
        idle(2);
        check("both_refund_vld", 32'(refund_vld), 32'd1);
        check("both_refund_val", 32'(refund_val), 32'd7);
        idle(4);
        check("both_not_busy", 32'(busy), 32'd0);

        cycle(1'b1, 4'd4, 1'b0, 1'b0);
        idle(2);
        cycle(1'b0, 4'd0, 1'b1, 1'b0);
        idle(3);
        ena = 1'b0;
        snap = dut_vec();
        cycle(1'b1, 4'd5, 1'b1, 1'b0);
        idle(1999);
        check("ena0_hold", 32'(dut_vec()), 32'(snap));
        check("ena0_no_timeout", 32'(done), 32'd0);
        ena = 1'b1;
        idle(5);
        check("ena1_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #4;
        do_reset();

        ra = 1'b0;
        rc = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            ena = $urandom_range(0, 19) != 0;
            if ($urandom_range(0, 3) == 0) ra = ~ra;
            if ($urandom_range(0, 39) == 0) rc = ~rc;
            cycle($urandom_range(0, 4) == 0, 4'($urandom_range(0, 15)), ra, rc);
        end
        ena = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
